// File: rtl/box_tracker.sv
// Box tracker: accumulates in-window colour hits per frame, divides the
// coordinate sums by the hit count to find the centroid, and re-centres the
// tracked box on it. Repeated weak frames declare the target lost.
module box_tracker #(
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479,
    parameter int MARGIN     = 16,
    parameter int MIN_COUNT  = 32,
    parameter int MISS_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        CLEAR,
    input  logic        SEED_LOAD,
    input  logic [11:0] SEED_TLX,
    input  logic [11:0] SEED_TLY,
    input  logic [11:0] SEED_BRX,
    input  logic [11:0] SEED_BRY,
    input  logic        FRAME_START,
    input  logic        FRAME_END,
    input  logic        PIX_VALID,
    input  logic [11:0] PIX_X,
    input  logic [11:0] PIX_Y,
    input  logic        PIX_HIT,
    output logic [11:0] TLX,
    output logic [11:0] TLY,
    output logic [11:0] BRX,
    output logic [11:0] BRY,
    output logic        BOX_VALID,
    output logic        UPDATE,
    output logic        LOST
);

    typedef enum logic [2:0] {IDLE, ACCUM, DIV_X, DIV_Y, UPDT} stateType;

    localparam logic [12:0] XMAX13    = 13'(X_MAX);
    localparam logic [12:0] YMAX13    = 13'(Y_MAX);
    localparam logic [11:0] XMAX12    = 12'(X_MAX);
    localparam logic [11:0] YMAX12    = 12'(Y_MAX);
    localparam logic [12:0] MARGIN13  = 13'(MARGIN);
    localparam logic [23:0] MIN_CNT   = 24'(MIN_COUNT);
    localparam logic [7:0]  MISS_LAST = 8'(MISS_LIMIT - 1);

    stateType    r_state;
    stateType    w_nextState;
    logic [11:0] r_tlx, r_tly, r_brx, r_bry;
    logic        r_boxValid, r_update, r_lost;
    logic [7:0]  r_miss;
    logic [23:0] r_count;
    logic [35:0] r_sumX, r_sumY;
    logic [35:0] r_quo;
    logic [23:0] r_rem;
    logic [5:0]  r_bitCnt;
    logic [11:0] r_cx, r_cy;

    // Search window: current box grown by MARGIN, clamped to the frame
    logic [12:0] w_wxl, w_wxh, w_wyl, w_wyh, w_wxhRaw, w_wyhRaw;
    logic        w_pixCounted;
    assign w_wxl    = ({1'b0, r_tlx} >= MARGIN13) ? ({1'b0, r_tlx} - MARGIN13) : 13'd0;
    assign w_wyl    = ({1'b0, r_tly} >= MARGIN13) ? ({1'b0, r_tly} - MARGIN13) : 13'd0;
    assign w_wxhRaw = {1'b0, r_brx} + MARGIN13;
    assign w_wyhRaw = {1'b0, r_bry} + MARGIN13;
    assign w_wxh    = (w_wxhRaw > XMAX13) ? XMAX13 : w_wxhRaw;
    assign w_wyh    = (w_wyhRaw > YMAX13) ? YMAX13 : w_wyhRaw;
    assign w_pixCounted = PIX_VALID && PIX_HIT
                       && ({1'b0, PIX_X} >= w_wxl) && ({1'b0, PIX_X} <= w_wxh)
                       && ({1'b0, PIX_Y} >= w_wyl) && ({1'b0, PIX_Y} <= w_wyh);

    // Frame outcome decisions, taken on the registered count
    logic w_enough, w_missOut, w_seedNonZero;
    assign w_enough      = (r_count >= MIN_CNT);
    assign w_missOut     = (r_miss == MISS_LAST);
    assign w_seedNonZero = |{SEED_TLX, SEED_TLY, SEED_BRX, SEED_BRY};

    // Restoring divider step: shift in the next dividend bit, subtract if it fits
    logic [24:0] w_trial, w_remNext;
    logic        w_ge, w_divLast;
    logic [35:0] w_quoNext;
    assign w_trial   = {r_rem, r_quo[35]};
    assign w_ge      = (w_trial >= {1'b0, r_count});
    assign w_remNext = w_ge ? (w_trial - {1'b0, r_count}) : w_trial;
    assign w_quoNext = {r_quo[34:0], w_ge};
    assign w_divLast = (r_bitCnt == 6'd35);

    // New box: keep the current half-size around the centroid, clamp to the frame
    logic [11:0] w_boxW, w_boxH, w_newTlx, w_newTly, w_newBrx, w_newBry;
    logic [12:0] w_halfW, w_halfH, w_cx13, w_cy13, w_brxSum, w_brySum;
    logic        w_newAllZero;
    assign w_boxW   = r_brx - r_tlx;
    assign w_boxH   = r_bry - r_tly;
    assign w_halfW  = {1'b0, w_boxW >> 1};
    assign w_halfH  = {1'b0, w_boxH >> 1};
    assign w_cx13   = {1'b0, r_cx};
    assign w_cy13   = {1'b0, r_cy};
    assign w_brxSum = w_cx13 + w_halfW;
    assign w_brySum = w_cy13 + w_halfH;
    assign w_newTlx = (w_cx13 >= w_halfW) ? 12'(w_cx13 - w_halfW) : 12'd0;
    assign w_newTly = (w_cy13 >= w_halfH) ? 12'(w_cy13 - w_halfH) : 12'd0;
    assign w_newBrx = (w_brxSum > XMAX13) ? XMAX12 : 12'(w_brxSum);
    assign w_newBry = (w_brySum > YMAX13) ? YMAX12 : 12'(w_brySum);
    assign w_newAllZero = ~|{w_newTlx, w_newTly, w_newBrx, w_newBry};

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic with SEED_LOAD > CLEAR > ENABLE low > normal flow
    always_comb begin
        w_nextState = r_state;
        if (SEED_LOAD) begin
            w_nextState = (ENABLE && w_seedNonZero) ? ACCUM : IDLE;
        end else if (CLEAR || !ENABLE) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (r_boxValid) w_nextState = ACCUM;
                ACCUM:   if (FRAME_END) begin
                             if (w_enough)       w_nextState = DIV_X;
                             else if (w_missOut) w_nextState = IDLE;
                         end
                DIV_X:   if (w_divLast) w_nextState = DIV_Y;
                DIV_Y:   if (w_divLast) w_nextState = UPDT;
                UPDT:    w_nextState = ACCUM;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Box, accumulator, miss counter and divider datapath. A pixel arriving in
    // the FRAME_END cycle is not counted: the frame decision uses the
    // registered count and the divider must see a stable count.
    // An all-zero seed or an all-zero result is never presented as valid so
    // that the all-zero box stays an unambiguous loss indication.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tlx <= '0; r_tly <= '0; r_brx <= '0; r_bry <= '0;
            r_boxValid <= 1'b0; r_update <= 1'b0; r_lost <= 1'b0;
            r_miss <= '0; r_count <= '0; r_sumX <= '0; r_sumY <= '0;
            r_quo <= '0; r_rem <= '0; r_bitCnt <= '0; r_cx <= '0; r_cy <= '0;
        end else begin
            r_update <= 1'b0;
            r_lost   <= 1'b0;
            if (SEED_LOAD) begin
                r_tlx <= SEED_TLX; r_tly <= SEED_TLY; r_brx <= SEED_BRX; r_bry <= SEED_BRY;
                r_boxValid <= w_seedNonZero;
                r_miss <= '0; r_count <= '0; r_sumX <= '0; r_sumY <= '0;
                r_quo <= '0; r_rem <= '0; r_bitCnt <= '0;
            end else if (CLEAR) begin
                r_tlx <= '0; r_tly <= '0; r_brx <= '0; r_bry <= '0;
                r_boxValid <= 1'b0;
                r_miss <= '0; r_count <= '0; r_sumX <= '0; r_sumY <= '0;
                r_quo <= '0; r_rem <= '0; r_bitCnt <= '0;
            end else if (ENABLE) begin
                case (r_state)
                    IDLE: if (r_boxValid) begin
                        r_count <= '0; r_sumX <= '0; r_sumY <= '0;
                    end
                    ACCUM: if (FRAME_END) begin
                        if (w_enough) begin
                            r_miss <= '0;
                            r_quo <= r_sumX; r_rem <= '0; r_bitCnt <= '0;
                        end else if (w_missOut) begin
                            r_tlx <= '0; r_tly <= '0; r_brx <= '0; r_bry <= '0;
                            r_boxValid <= 1'b0;
                            r_lost <= 1'b1;
                            r_miss <= '0;
                        end else begin
                            r_miss <= r_miss + 8'd1;
                        end
                    end else if (FRAME_START) begin
                        r_count <= w_pixCounted ? 24'd1 : 24'd0;
                        r_sumX  <= w_pixCounted ? {24'd0, PIX_X} : 36'd0;
                        r_sumY  <= w_pixCounted ? {24'd0, PIX_Y} : 36'd0;
                    end else if (w_pixCounted) begin
                        r_count <= r_count + 24'd1;
                        r_sumX  <= r_sumX + {24'd0, PIX_X};
                        r_sumY  <= r_sumY + {24'd0, PIX_Y};
                    end
                    DIV_X: begin
                        r_quo <= w_quoNext; r_rem <= 24'(w_remNext); r_bitCnt <= r_bitCnt + 6'd1;
                        if (w_divLast) begin
                            r_cx <= w_quoNext[11:0];
                            r_quo <= r_sumY; r_rem <= '0; r_bitCnt <= '0;
                        end
                    end
                    DIV_Y: begin
                        r_quo <= w_quoNext; r_rem <= 24'(w_remNext); r_bitCnt <= r_bitCnt + 6'd1;
                        if (w_divLast) begin
                            r_cy <= w_quoNext[11:0];
                            r_bitCnt <= '0;
                        end
                    end
                    UPDT: begin
                        r_count <= '0; r_sumX <= '0; r_sumY <= '0;
                        if (!w_newAllZero) begin
                            r_tlx <= w_newTlx; r_tly <= w_newTly;
                            r_brx <= w_newBrx; r_bry <= w_newBry;
                            r_update <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign TLX       = r_tlx;
    assign TLY       = r_tly;
    assign BRX       = r_brx;
    assign BRY       = r_bry;
    assign BOX_VALID = r_boxValid;
    assign UPDATE    = r_update;
    assign LOST      = r_lost;

endmodule
